// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score keeper: match states, BCD digits,
// player indices and a binary-to-BCD helper for elaboration-time constants.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Converts 0..99 into {tens, ones} BCD.
  function automatic logic [7:0] to_bcd2(input int value);
    logic [3:0] tens_v;
    logic [3:0] ones_v;
    tens_v = 4'((value / 10) % 10);
    ones_v = 4'(value % 10);
    return {tens_v, ones_v};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter with synchronous clear and a flag that says the
// next increment lands exactly on the target score.
module bcd_counter2
  import pong_pkg::*;
#(
  parameter int TARGET = 11
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic next_at_target
);

  localparam logic [7:0] PRE_BCD = to_bcd2(TARGET - 1);

  bcd_t tens_r;
  bcd_t ones_r;

  // Digit registers: clear wins over increment, ones carries into tens at 9.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens_r <= 4'd0;
      ones_r <= 4'd0;
    end else if (clr) begin
      tens_r <= 4'd0;
      ones_r <= 4'd0;
    end else if (inc) begin
      if (ones_r == 4'd9) begin
        ones_r <= 4'd0;
        tens_r <= (tens_r == 4'd9) ? 4'd0 : tens_r + 4'd1;
      end else begin
        ones_r <= ones_r + 4'd1;
      end
    end else begin
      tens_r <= tens_r;
      ones_r <= ones_r;
    end
  end

  assign tens           = tens_r;
  assign ones           = ones_r;
  assign next_at_target = ({tens_r, ones_r} == PRE_BCD);

endmodule

// File: rtl/pong_score_keeper.sv
// Pong match sequencer: point edge detection, serve hold timer, IDLE/HOLD/PLAY/OVER
// state machine and one BCD score counter per player. All outputs are registered.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       new_game,
  output logic [3:0] score_l_tens,
  output logic [3:0] score_l_ones,
  output logic [3:0] score_r_tens,
  output logic [3:0] score_r_ones,
  output logic       serve,
  output logic       playing,
  output logic       game_over,
  output logic       winner
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            pl_r;
  logic            pr_r;
  logic            inc_l_s;
  logic            inc_r_s;
  logic            clr_s;
  logic            add_l_s;
  logic            add_r_s;
  logic            hit_l_s;
  logic            hit_r_s;
  logic            win_side_s;
  logic            serve_s;
  logic            playing_s;
  logic            game_over_s;
  logic            winner_s;
  logic            serve_r;
  logic            playing_r;
  logic            game_over_r;
  logic            winner_r;

  assign inc_l_s = point_l & ~pl_r;
  assign inc_r_s = point_r & ~pr_r;

  // State, hold timer and edge-detect registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      pl_r    <= 1'b0;
      pr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pl_r    <= point_l;
      pr_r    <= point_r;
    end
  end

  // Next-state logic; new_game restarts from any state and beats a point edge.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    clr_s      = 1'b0;
    add_l_s    = 1'b0;
    add_r_s    = 1'b0;
    win_side_s = winner_r;
    if (new_game) begin
      clr_s   = 1'b1;
      cnt_s   = ZERO;
      state_s = HOLD;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        HOLD: begin
          if (cnt_r == LAST) begin
            state_s = PLAY;
            cnt_s   = ZERO;
          end else begin
            cnt_s = cnt_r + ONE;
          end
        end
        PLAY: begin
          // Simultaneous edges on both sides are a glitch and score nothing.
          if (inc_l_s && !inc_r_s) begin
            add_l_s = 1'b1;
            if (hit_l_s) begin
              state_s    = OVER;
              win_side_s = LEFT;
            end else begin
              state_s = HOLD;
              cnt_s   = ZERO;
            end
          end else if (inc_r_s && !inc_l_s) begin
            add_r_s = 1'b1;
            if (hit_r_s) begin
              state_s    = OVER;
              win_side_s = RIGHT;
            end else begin
              state_s = HOLD;
              cnt_s   = ZERO;
            end
          end else begin
            state_s = PLAY;
          end
        end
        OVER: begin
          state_s = OVER;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    serve_s     = (state_s == HOLD) && (cnt_s == LAST);
    playing_s   = (state_s == PLAY);
    game_over_s = (state_s == OVER);
    if (state_s == OVER) begin
      winner_s = win_side_s;
    end else begin
      winner_s = LEFT;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serve_r     <= 1'b0;
      playing_r   <= 1'b0;
      game_over_r <= 1'b0;
      winner_r    <= 1'b0;
    end else begin
      serve_r     <= serve_s;
      playing_r   <= playing_s;
      game_over_r <= game_over_s;
      winner_r    <= winner_s;
    end
  end

  bcd_counter2 #(.TARGET(WIN_SCORE)) u_score_l (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr            (clr_s),
    .inc            (add_l_s),
    .tens           (score_l_tens),
    .ones           (score_l_ones),
    .next_at_target (hit_l_s)
  );

  bcd_counter2 #(.TARGET(WIN_SCORE)) u_score_r (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr            (clr_s),
    .inc            (add_r_s),
    .tens           (score_r_tens),
    .ones           (score_r_ones),
    .next_at_target (hit_r_s)
  );

  assign serve     = serve_r;
  assign playing   = playing_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: two instances (WIN 21/HOLD 4 and WIN 3/HOLD 1) share
// stimulus; a vector table, directed sequences and random play against a score model.
module tb_pong_score_keeper;

  typedef struct packed {
    logic [3:0] lt;
    logic [3:0] lo;
    logic [3:0] rt;
    logic [3:0] ro;
    logic       srv;
    logic       ply;
    logic       ovr;
    logic       win;
  } obs_t;

  typedef struct {
    logic pl;
    logic pr;
    logic ng;
    int   sl;
    int   sr;
    logic srv;
    logic ply;
    logic ovr;
  } vec_t;

  localparam int S_IDLE = 0, S_HOLD = 1, S_PLAY = 2, S_OVER = 3;
  localparam int P_W [2] = '{21, 3};
  localparam int P_H [2] = '{4, 1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic point_l = 1'b0;
  logic point_r = 1'b0;
  logic new_game = 1'b0;

  logic [3:0] a_lt, a_lo, a_rt, a_ro, b_lt, b_lo, b_rt, b_ro;
  logic       a_srv, a_ply, a_ovr, a_win, b_srv, b_ply, b_ovr, b_win;
  obs_t       obs [2];

  int checks = 0;
  int failures = 0;

  int   m_st [2];
  int   m_sl [2];
  int   m_sr [2];
  int   m_ht [2];
  int   m_win [2];
  logic m_pl [2];
  logic m_pr [2];

  vec_t tbl [16];

  always #5 clk = ~clk;

  pong_score_keeper #(.WIN_SCORE(21), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .point_l(point_l), .point_r(point_r), .new_game(new_game),
    .score_l_tens(a_lt), .score_l_ones(a_lo), .score_r_tens(a_rt), .score_r_ones(a_ro),
    .serve(a_srv), .playing(a_ply), .game_over(a_ovr), .winner(a_win)
  );

  pong_score_keeper #(.WIN_SCORE(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .point_l(point_l), .point_r(point_r), .new_game(new_game),
    .score_l_tens(b_lt), .score_l_ones(b_lo), .score_r_tens(b_rt), .score_r_ones(b_ro),
    .serve(b_srv), .playing(b_ply), .game_over(b_ovr), .winner(b_win)
  );

  assign obs[0] = {a_lt, a_lo, a_rt, a_ro, a_srv, a_ply, a_ovr, a_win};
  assign obs[1] = {b_lt, b_lo, b_rt, b_ro, b_srv, b_ply, b_ovr, b_win};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_sl[i] = 0; m_sr[i] = 0; m_ht[i] = 0; m_win[i] = 0;
      m_pl[i] = 1'b0; m_pr[i] = 1'b0;
    end
  endtask

  // Match rules applied to integer scores at one clock edge.
  task automatic model_step();
    logic el, er;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        el = point_l && !m_pl[i];
        er = point_r && !m_pr[i];
        m_pl[i] = point_l;
        m_pr[i] = point_r;
        if (new_game) begin
          m_sl[i] = 0; m_sr[i] = 0; m_st[i] = S_HOLD; m_ht[i] = 0;
        end else if (m_st[i] == S_HOLD) begin
          if (m_ht[i] == P_H[i] - 1) m_st[i] = S_PLAY;
          else m_ht[i] = m_ht[i] + 1;
        end else if (m_st[i] == S_PLAY && el != er) begin
          if (el) m_sl[i] = m_sl[i] + 1;
          else    m_sr[i] = m_sr[i] + 1;
          if (m_sl[i] == P_W[i] || m_sr[i] == P_W[i]) begin
            m_st[i] = S_OVER;
            m_win[i] = er ? 1 : 0;
          end else begin
            m_st[i] = S_HOLD;
            m_ht[i] = 0;
          end
        end
      end
    end
  endtask

  function automatic obs_t model_obs(int i);
    obs_t o;
    o.lt  = 4'(m_sl[i] / 10);
    o.lo  = 4'(m_sl[i] % 10);
    o.rt  = 4'(m_sr[i] / 10);
    o.ro  = 4'(m_sr[i] % 10);
    o.srv = (m_st[i] == S_HOLD) && (m_ht[i] == P_H[i] - 1);
    o.ply = (m_st[i] == S_PLAY);
    o.ovr = (m_st[i] == S_OVER);
    o.win = o.ovr && (m_win[i] == 1);
    return o;
  endfunction

  task automatic check_model(string tag);
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      e = model_obs(i);
      checks++;
      if (obs[i] !== e) begin
        failures++;
        $display("FAIL %s dut%0d t=%0t got=%h expected=%h", tag, i, $time, obs[i], e);
      end
    end
  endtask

  task automatic check_val(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic wait_play(int i);
    int n;
    n = 0;
    point_l = 1'b0;
    point_r = 1'b0;
    while (!obs[i].ply && n < 20) begin
      step("wait");
      n++;
    end
    check_val("wait_play_timeout", int'(obs[i].ply), 1);
  endtask

  function automatic vec_t mk(int pl, int pr, int ng, int sl, int sr, int srv, int ply, int ovr);
    vec_t v;
    v.pl = pl[0]; v.pr = pr[0]; v.ng = ng[0]; v.sl = sl; v.sr = sr;
    v.srv = srv[0]; v.ply = ply[0]; v.ovr = ovr[0];
    return v;
  endfunction

  initial begin
    int got_sl, got_sr;
    // Expected behaviour of dut_a (WIN 21, HOLD 4) straight after reset.
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 0, 0, 1, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 1, 0);
    tbl[12] = mk(1, 1, 0, 1, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 1, 0);
    tbl[14] = mk(1, 0, 1, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0);

    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset_a", int'(obs[0]), 0);
    check_val("reset_b", int'(obs[1]), 0);
    reset_n = 1'b1;
    step("idle");

    for (int r = 0; r < 16; r++) begin
      point_l = tbl[r].pl; point_r = tbl[r].pr; new_game = tbl[r].ng;
      step("tbl_model");
      got_sl = 10 * int'(obs[0].lt) + int'(obs[0].lo);
      got_sr = 10 * int'(obs[0].rt) + int'(obs[0].ro);
      checks++;
      if (got_sl != tbl[r].sl || got_sr != tbl[r].sr || obs[0].srv !== tbl[r].srv ||
          obs[0].ply !== tbl[r].ply || obs[0].ovr !== tbl[r].ovr) begin
        failures++;
        $display("FAIL tbl[%0d] got sl=%0d sr=%0d srv=%b ply=%b ovr=%b expected sl=%0d sr=%0d srv=%b ply=%b ovr=%b",
                 r, got_sl, got_sr, obs[0].srv, obs[0].ply, obs[0].ovr,
                 tbl[r].sl, tbl[r].sr, tbl[r].srv, tbl[r].ply, tbl[r].ovr);
      end
    end
    point_l = 1'b0; point_r = 1'b0; new_game = 1'b0;

    // Left score on dut_a through 09 -> 10.
    new_game = 1'b1; step("ng_a"); new_game = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_play(0);
      point_l = 1'b1; step("pt_l"); point_l = 1'b0; step("pt_l_low");
    end
    check_val("a_left_09", 10 * int'(obs[0].lt) + int'(obs[0].lo), 9);
    wait_play(0);
    point_l = 1'b1; step("pt_l_10");
    check_val("a_left_tens", int'(obs[0].lt), 1);
    check_val("a_left_ones", int'(obs[0].lo), 0);
    point_l = 1'b0;

    // dut_b: right wins 3-0, scores then freeze, new_game clears.
    new_game = 1'b1; step("ng_b"); new_game = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_play(1);
      point_r = 1'b1; step("pt_r");
      point_r = 1'b0;
    end
    check_val("b_game_over", int'(obs[1].ovr), 1);
    check_val("b_winner", int'(obs[1].win), 1);
    check_val("b_right_score", 10 * int'(obs[1].rt) + int'(obs[1].ro), 3);
    step("over_low");
    point_r = 1'b1; step("over_edge"); point_r = 1'b0;
    check_val("b_frozen", 10 * int'(obs[1].rt) + int'(obs[1].ro), 3);
    new_game = 1'b1; step("ng_over"); new_game = 1'b0;
    check_val("b_cleared", int'({obs[1].lt, obs[1].lo, obs[1].rt, obs[1].ro}), 0);
    check_val("b_hold_serve", int'({obs[1].srv, obs[1].ply, obs[1].ovr}), 4);

    // Asynchronous reset in the middle of dut_a's HOLD.
    new_game = 1'b1; step("ng_rst"); new_game = 1'b0;
    step("hold1");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_val("async_reset_a", int'(obs[0]), 0);
    check_val("async_reset_b", int'(obs[1]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step("post_reset");
      check_val("no_serve_a", int'({obs[0].srv, obs[0].ply}), 0);
      check_val("no_serve_b", int'({obs[1].srv, obs[1].ply}), 0);
    end

    // Random play against the model.
    for (int k = 0; k < 3000; k++) begin
      new_game = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) point_l = ~point_l;
      if ($urandom_range(0, 3) == 0) point_r = ~point_r;
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
